// File: rtl/ebus_xfer_ctl.sv
// rtl/ebus_xfer_ctl.sv - EBUS CPU I/O transfer sequencer (CONO/CONI/DATAO/DATAI)
//
// Purpose:
//   Runs one CPU I/O transfer between the EDP data path and the EBUS. The
//   controller presents the device select and function, raises demand, and
//   waits for the device transfer acknowledge. It then drops demand and waits
//   for the acknowledge to fall. Each of the two handshake waits has its own
//   bounded timeout. For writes it tells EDP when to drive AD onto the EBUS.
//   For reads it captures ebusD and pulses an AR-load strobe back to EDP.
//
// Ports:
//   clk, reset_n       clock; asynchronous active-low reset
//   start, func, dev   transfer request; accepted only in IDLE
//   abort              synchronous abandon (SETUP/DEMAND/HOLD only)
//   ebusXfer, ebusD    device acknowledge and EBUS data (bit 0 = MSB)
//   busy, done         not-idle flag; one-cycle completion pulse
//   timeout, illegal   sticky status, cleared by the next accepted start
//   ebusCS, ebusFunc   device select / function presented to the bus
//   ebusDemand         demand to the device
//   adToEBUS_L/_R      EDP drives AD halves onto the EBUS (writes)
//   ebusLatch          captured read data
//   arLoadEbus         one-cycle strobe: load AR from EBUS

module ebus_xfer_ctl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  func,
  input  logic [6:0]  dev,
  input  logic        abort,
  input  logic        ebusXfer,
  input  logic [35:0] ebusD,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        illegal,
  output logic [6:0]  ebusCS,
  output logic [2:0]  ebusFunc,
  output logic        ebusDemand,
  output logic        adToEBUS_L,
  output logic        adToEBUS_R,
  output logic [35:0] ebusLatch,
  output logic        arLoadEbus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_DEMAND,
    S_HOLD,
    S_RELEASE,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       cs_q, cs_d;
  logic [2:0]       fn_q, fn_d;
  logic             timeout_q, timeout_d;
  logic             illegal_q, illegal_d;
  logic [35:0]      latch_q, latch_d;

  // Legal functions: bit 0 clear = write (CONO, DATAO), set = read (CONI, DATAI).
  logic is_read;
  assign is_read = fn_q[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cs_q      <= '0;
      fn_q      <= '0;
      timeout_q <= 1'b0;
      illegal_q <= 1'b0;
      latch_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cs_q      <= cs_d;
      fn_q      <= fn_d;
      timeout_q <= timeout_d;
      illegal_q <= illegal_d;
      latch_q   <= latch_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;           // counter restarts on every state change
    cs_d      = cs_q;
    fn_d      = fn_q;
    timeout_d = timeout_q;
    illegal_d = illegal_q;
    latch_d   = latch_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          timeout_d = 1'b0;
          if (func[2]) begin
            illegal_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            illegal_d = 1'b0;
            cs_d      = dev;
            fn_d      = func;
            state_d   = S_SETUP;
          end
        end
      end

      S_SETUP: begin
        state_d = abort ? S_RELEASE : S_DEMAND;
      end

      S_DEMAND: begin
        // Abort wins over a same-edge acknowledge: no capture, no HOLD.
        if (abort) begin
          state_d = S_RELEASE;
        end else if (ebusXfer) begin
          state_d = S_HOLD;
          if (is_read) begin
            latch_d = ebusD;
          end
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_HOLD: begin
        state_d = S_RELEASE;
      end

      S_RELEASE: begin
        if (!ebusXfer) begin
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bus select and function are withdrawn for the DONE cycle.
    if (state_d == S_DONE) begin
      cs_d = '0;
      fn_d = '0;
    end
  end

  logic drive_ad;
  assign drive_ad = !is_read &&
                    (state_q == S_SETUP || state_q == S_DEMAND || state_q == S_HOLD);

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign timeout    = timeout_q;
  assign illegal    = illegal_q;
  assign ebusCS     = cs_q;
  assign ebusFunc   = fn_q;
  assign ebusDemand = (state_q == S_DEMAND) || (state_q == S_HOLD);
  assign adToEBUS_L = drive_ad;
  assign adToEBUS_R = drive_ad;
  assign ebusLatch  = latch_q;
  // An abort sampled during HOLD suppresses that cycle's AR load.
  assign arLoadEbus = (state_q == S_HOLD) && is_read && !abort;

endmodule

// File: tb/tb_ebus_xfer_ctl.sv
// tb/tb_ebus_xfer_ctl.sv - directed self-checking bench for ebus_xfer_ctl

module tb_ebus_xfer_ctl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  func;
  logic [6:0]  dev;
  logic        abort;
  logic        ebusXfer;
  logic [35:0] ebusD;
  logic        busy, done, timeout, illegal;
  logic [6:0]  ebusCS;
  logic [2:0]  ebusFunc;
  logic        ebusDemand, adToEBUS_L, adToEBUS_R;
  logic [35:0] ebusLatch;
  logic        arLoadEbus;

  int n_vec  = 0;
  int n_miss = 0;

  // Per-transfer observations filled in by run_xfer.
  int         r_done_k, r_dem, r_ad, r_arl, r_viol;
  logic       r_to, r_ill, r_to1, r_ill1;
  logic [6:0] r_cs1, r_csd;
  logic [2:0] r_fn1, r_fnd;

  always #5 clk = ~clk;

  ebus_xfer_ctl #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .func       (func),
    .dev        (dev),
    .abort      (abort),
    .ebusXfer   (ebusXfer),
    .ebusD      (ebusD),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .illegal    (illegal),
    .ebusCS     (ebusCS),
    .ebusFunc   (ebusFunc),
    .ebusDemand (ebusDemand),
    .adToEBUS_L (adToEBUS_L),
    .adToEBUS_R (adToEBUS_R),
    .ebusLatch  (ebusLatch),
    .arLoadEbus (arLoadEbus)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Cycle k=0 is the negedge where start is driven; k=1 is the first cycle
  // after the accepting edge. Inputs are driven and outputs sampled on negedges.
  // ebusXfer is high for k in [xfer_at, xfer_at+xfer_len); abort pulses at k==abort_at.
  task automatic run_xfer(input logic [2:0] f, input logic [6:0] d, input logic [35:0] data,
                          input int xfer_at, input int xfer_len, input int abort_at);
    bit got_done;
    r_done_k = -1; r_dem = 0; r_ad = 0; r_arl = 0; r_viol = 0;
    r_to = 1'b0; r_ill = 1'b0; r_to1 = 1'b1; r_ill1 = 1'b1;
    r_cs1 = '1; r_fn1 = '1; r_csd = '1; r_fnd = '1;
    got_done = 1'b0;
    @(negedge clk);
    start = 1'b1; func = f; dev = d; ebusD = data;
    ebusXfer = 1'b0; abort = (abort_at == 0);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (ebusDemand) r_dem++;
      if (adToEBUS_L) r_ad++;
      if (arLoadEbus) r_arl++;
      if (adToEBUS_L != adToEBUS_R) r_viol++;
      if (arLoadEbus && done) r_viol++;
      if (done && (ebusDemand || adToEBUS_L || adToEBUS_R)) r_viol++;
      if (!busy && (ebusDemand || adToEBUS_L || adToEBUS_R)) r_viol++;
      if (k == 1) begin
        r_cs1 = ebusCS; r_fn1 = ebusFunc; r_to1 = timeout; r_ill1 = illegal;
      end
      start    = 1'b0;
      ebusXfer = (k >= xfer_at) && (k < xfer_at + xfer_len);
      abort    = (k == abort_at);
      if (done) begin
        r_done_k = k; r_to = timeout; r_ill = illegal;
        r_csd = ebusCS; r_fnd = ebusFunc;
        got_done = 1'b1;
        break;
      end
    end
    ebusXfer = 1'b0;
    abort    = 1'b0;
    @(negedge clk);
    if (got_done && (done || busy)) r_viol++;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; func = '0; dev = '0;
    abort = 1'b0; ebusXfer = 1'b0; ebusD = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("reset_busy",  64'(busy), 64'd0);
    check_eq("reset_done",  64'(done), 64'd0);
    check_eq("reset_flags", 64'({timeout, illegal}), 64'd0);
    check_eq("reset_bus",   64'({ebusCS, ebusFunc, ebusDemand, adToEBUS_L, adToEBUS_R, arLoadEbus}), 64'd0);
    check_eq("reset_latch", 64'(ebusLatch), 64'd0);

    // DATAI, acknowledge on 2nd DEMAND cycle, dropped one cycle later.
    run_xfer(3'd3, 7'o004, 36'o123456701234, 3, 1, -1);
    check_eq("datai_cs",     64'(r_cs1), 64'(7'o004));
    check_eq("datai_fn",     64'(r_fn1), 64'd3);
    check_eq("datai_done_k", 64'(r_done_k), 64'd6);
    check_eq("datai_latch",  64'(ebusLatch), 64'o123456701234);
    check_eq("datai_arl",    64'(r_arl), 64'd1);
    check_eq("datai_dem",    64'(r_dem), 64'd3);
    check_eq("datai_ad",     64'(r_ad), 64'd0);
    check_eq("datai_to",     64'(r_to), 64'd0);
    check_eq("datai_done_bus", 64'({r_csd, r_fnd}), 64'd0);
    check_eq("datai_viol",   64'(r_viol), 64'd0);

    // DATAO, immediate acknowledge.
    run_xfer(3'd2, 7'o010, 36'o555555555555, 1, 2, -1);
    check_eq("datao_cs",     64'(r_cs1), 64'(7'o010));
    check_eq("datao_done_k", 64'(r_done_k), 64'd5);
    check_eq("datao_ad",     64'(r_ad), 64'd3);
    check_eq("datao_dem",    64'(r_dem), 64'd2);
    check_eq("datao_arl",    64'(r_arl), 64'd0);
    check_eq("datao_latch",  64'(ebusLatch), 64'o123456701234);
    check_eq("datao_viol",   64'(r_viol), 64'd0);

    // DATAI with abort on the same edge as the acknowledge.
    run_xfer(3'd3, 7'o004, 36'o777777777777, 2, 1, 2);
    check_eq("abort_done_k", 64'(r_done_k), 64'd4);
    check_eq("abort_arl",    64'(r_arl), 64'd0);
    check_eq("abort_dem",    64'(r_dem), 64'd1);
    check_eq("abort_latch",  64'(ebusLatch), 64'o123456701234);
    check_eq("abort_to",     64'(r_to), 64'd0);
    check_eq("abort_viol",   64'(r_viol), 64'd0);

    // CONI, device never answers: DEMAND timeout.
    run_xfer(3'd1, 7'o020, 36'o0, 1000, 0, -1);
    check_eq("demto_done_k", 64'(r_done_k), 64'd67);
    check_eq("demto_dem",    64'(r_dem), 64'd64);
    check_eq("demto_to",     64'(r_to), 64'd1);
    check_eq("demto_sticky", 64'(timeout), 64'd1);
    check_eq("demto_latch",  64'(ebusLatch), 64'o123456701234);
    check_eq("demto_viol",   64'(r_viol), 64'd0);

    // CONO clears the sticky timeout.
    run_xfer(3'd0, 7'o030, 36'o0, 1, 2, -1);
    check_eq("cono_to_clr",  64'(r_to1), 64'd0);
    check_eq("cono_done_k",  64'(r_done_k), 64'd5);
    check_eq("cono_ad",      64'(r_ad), 64'd3);

    // DATAI, device never drops acknowledge: RELEASE timeout.
    run_xfer(3'd3, 7'o040, 36'o765432101234, 1, 1000, -1);
    check_eq("relto_done_k", 64'(r_done_k), 64'd68);
    check_eq("relto_to",     64'(r_to), 64'd1);
    check_eq("relto_arl",    64'(r_arl), 64'd1);
    check_eq("relto_dem",    64'(r_dem), 64'd2);
    check_eq("relto_latch",  64'(ebusLatch), 64'o765432101234);

    // Illegal function.
    run_xfer(3'd5, 7'o050, 36'o0, 1000, 0, -1);
    check_eq("ill_done_k",   64'(r_done_k), 64'd1);
    check_eq("ill_flag",     64'(r_ill), 64'd1);
    check_eq("ill_to_clr",   64'(r_to), 64'd0);
    check_eq("ill_dem",      64'(r_dem), 64'd0);
    check_eq("ill_cs",       64'({r_cs1, r_fn1}), 64'd0);
    check_eq("ill_sticky",   64'(illegal), 64'd1);

    // CONO clears illegal.
    run_xfer(3'd0, 7'o060, 36'o0, 1, 2, -1);
    check_eq("cono_ill_clr", 64'(r_ill1), 64'd0);
    check_eq("cono2_ill",    64'(r_ill), 64'd0);
    check_eq("cono2_done_k", 64'(r_done_k), 64'd5);

    // Asynchronous reset mid-DEMAND.
    @(negedge clk);
    start = 1'b1; func = 3'd2; dev = 7'o010;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_dem",  64'(ebusDemand), 64'd1);
    check_eq("pre_rst_ad",   64'({adToEBUS_L, adToEBUS_R}), 64'd3);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_busy",     64'(busy), 64'd0);
    check_eq("rst_dem_ad",   64'({ebusDemand, adToEBUS_L, adToEBUS_R}), 64'd0);
    check_eq("rst_latch",    64'(ebusLatch), 64'd0);
    check_eq("rst_cs",       64'({ebusCS, ebusFunc}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_xfer(3'd3, 7'o004, 36'o777000111222, 1, 2, -1);
    check_eq("post_rst_done_k", 64'(r_done_k), 64'd5);
    check_eq("post_rst_latch",  64'(ebusLatch), 64'o777000111222);
    check_eq("post_rst_arl",    64'(r_arl), 64'd1);
    check_eq("post_rst_viol",   64'(r_viol), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
